// File: rtl/cache_req_seq.sv
// rtl/cache_req_seq.sv - request sequencer driving a dual-rail four-phase cache port
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake; req_write, req_addr, req_wdata payload
//   rsp_valid, rsp_rdata, rsp_err   one-cycle completion with read data / abort flag
//   c_addr, c_data_in               dual-rail address and write data to the cache
//   c_read_Nwrite                   [1]=read request, [0]=write request
//   c_ack_in_read                   acknowledge back to the cache read port
//   c_data_out                      dual-rail read data from the cache
//   c_ack_read, c_ack_write         asynchronous cache acknowledges (synchronized here)
// Optional feature: define ACK_TIMEOUT_EN to abort a handshake phase that exceeds
// TIMEOUT_CYCLES cycles; rsp_err is constant 0 otherwise.
module cache_req_seq #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  c_addr,
  output logic [15:0] c_data_in,
  output logic [1:0]  c_read_Nwrite,
  output logic        c_ack_in_read,
  input  logic [15:0] c_data_out,
  input  logic        c_ack_read,
  input  logic        c_ack_write
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT_ACK, RELEASE, RESP} state_t;

  state_t      state, state_n;
  logic        ackr_m, ackr_s, ackw_m, ackw_s;
  logic        wr_q, wr_n;
  logic [1:0]  addr_q, addr_n;
  logic [7:0]  wdata_q, wdata_n;
  logic [3:0]  c_addr_n;
  logic [15:0] c_data_in_n;
  logic [1:0]  c_rnw_n;
  logic        ack_in_n;
  logic        rsp_valid_n;
  logic [7:0]  rdata_n;
  logic        sel_ack;
  logic        timeout_hit;
  logic [7:0]  rd_true, rd_false;
  logic        unused_false_rail;

  // True rail at odd index, false rail at even index.
  function automatic logic [3:0] dual_rail2(input logic [1:0] v);
    logic [3:0] r;
    for (int i = 0; i < 2; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  function automatic logic [15:0] dual_rail8(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = v[i];
      r[2*i]   = ~v[i];
    end
    return r;
  endfunction

  always_comb begin
    rd_true  = '0;
    rd_false = '0;
    for (int i = 0; i < 8; i++) begin
      rd_true[i]  = c_data_out[2*i+1];
      rd_false[i] = c_data_out[2*i];
    end
  end

  // Read data is taken from the true rails only.
  assign unused_false_rail = ^rd_false;

  assign sel_ack   = wr_q ? ackw_s : ackr_s;
  assign req_ready = rst_n && (state == IDLE) && !ackr_s && !ackw_s;

`ifdef ACK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
  logic          err_q;

  assign timeout_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_err     = err_q;

  // Cleared on entry to each handshake phase, counts while in that phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == DRIVE || (state == WAIT_ACK && state_n == RELEASE)) begin
      tmo_cnt <= '0;
    end else if (state == WAIT_ACK || state == RELEASE) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Reaching RESP without the phase's ack condition being met means an abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state_n == RESP && state != RESP) begin
      err_q <= (state == WAIT_ACK) ? !sel_ack : sel_ack;
    end else begin
      err_q <= 1'b0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign rsp_err            = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    wr_n        = wr_q;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    c_addr_n    = c_addr;
    c_data_in_n = c_data_in;
    c_rnw_n     = c_read_Nwrite;
    ack_in_n    = c_ack_in_read;
    rsp_valid_n = 1'b0;
    rdata_n     = rsp_rdata;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          wr_n    = req_write;
          addr_n  = req_addr;
          wdata_n = req_wdata;
          state_n = DRIVE;
        end
      end
      DRIVE: begin
        c_addr_n = dual_rail2(addr_q);
        if (wr_q) begin
          c_data_in_n = dual_rail8(wdata_q);
          c_rnw_n     = 2'b01;
        end else begin
          c_data_in_n = '0;
          c_rnw_n     = 2'b10;
        end
        state_n = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (sel_ack) begin
          if (!wr_q) begin
            rdata_n  = rd_true;
            ack_in_n = 1'b1;
          end
          c_addr_n    = '0;
          c_data_in_n = '0;
          c_rnw_n     = '0;
          state_n     = RELEASE;
        end else if (timeout_hit) begin
          c_addr_n    = '0;
          c_data_in_n = '0;
          c_rnw_n     = '0;
          ack_in_n    = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RESP;
        end
      end
      RELEASE: begin
        if (!sel_ack) begin
          ack_in_n    = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RESP;
        end else if (timeout_hit) begin
          c_addr_n    = '0;
          c_data_in_n = '0;
          c_rnw_n     = '0;
          ack_in_n    = 1'b0;
          rsp_valid_n = 1'b1;
          state_n     = RESP;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ackr_m        <= 1'b0;
      ackr_s        <= 1'b0;
      ackw_m        <= 1'b0;
      ackw_s        <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      c_addr        <= '0;
      c_data_in     <= '0;
      c_read_Nwrite <= '0;
      c_ack_in_read <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      state         <= state_n;
      ackr_m        <= c_ack_read;
      ackr_s        <= ackr_m;
      ackw_m        <= c_ack_write;
      ackw_s        <= ackw_m;
      wr_q          <= wr_n;
      addr_q        <= addr_n;
      wdata_q       <= wdata_n;
      c_addr        <= c_addr_n;
      c_data_in     <= c_data_in_n;
      c_read_Nwrite <= c_rnw_n;
      c_ack_in_read <= ack_in_n;
      rsp_valid     <= rsp_valid_n;
      rsp_rdata     <= rdata_n;
    end
  end

endmodule

// File: tb/tb_cache_req_seq.sv
// tb/tb_cache_req_seq.sv - self-checking bench for cache_req_seq with a behavioural cache model
module tb_cache_req_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, c_ack_in_read;
  logic [7:0]  rsp_rdata;
  logic [3:0]  c_addr;
  logic [15:0] c_data_in, c_data_out;
  logic [1:0]  c_read_Nwrite;
  logic        c_ack_read, c_ack_write;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rd;
    logic [7:0] rdata;
    logic       err;
    logic [7:0] lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] last_rd = 8'h00;

  // Cache model controls
  logic [7:0]  m_data = 8'h00;
  int          m_delay = 0;
  logic        m_comb = 1'b0;
  logic        m_hang = 1'b0;
  logic        stuck_r = 1'b0;
  int          m_cnt = 0;
  logic        ackr_q = 1'b0;
  logic        ackw_q = 1'b0;
  logic [15:0] dout_q = '0;

  int cyc = 0;
  int acc_cyc = 0;
  int accepts = 0;
  int rsp_cnt = 0;
  logic prev_rsp = 1'b0;

  always #5 clk = ~clk;

  cache_req_seq #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .c_addr(c_addr), .c_data_in(c_data_in), .c_read_Nwrite(c_read_Nwrite),
    .c_ack_in_read(c_ack_in_read), .c_data_out(c_data_out),
    .c_ack_read(c_ack_read), .c_ack_write(c_ack_write)
  );

  function automatic logic [15:0] dr8(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [3:0] dr2(input logic [1:0] v);
    logic [3:0] r;
    for (int i = 0; i < 2; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Four-phase cache: raises ack after m_delay cycles of a request, drops it on spacer.
  always @(posedge clk) begin
    if (c_read_Nwrite == 2'b00) begin
      m_cnt  <= 0;
      ackr_q <= 1'b0;
      ackw_q <= 1'b0;
      dout_q <= '0;
    end else if (!m_hang) begin
      if (m_cnt >= m_delay) begin
        if (c_read_Nwrite[1]) begin
          ackr_q <= 1'b1;
          dout_q <= dr8(m_data);
        end else begin
          ackw_q <= 1'b1;
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  assign c_ack_read  = stuck_r | (m_comb ? (c_read_Nwrite[1] && !m_hang) : ackr_q);
  assign c_ack_write = m_comb ? (c_read_Nwrite[0] && !m_hang) : ackw_q;
  assign c_data_out  = m_comb ? ((c_read_Nwrite[1] && !m_hang) ? dr8(m_data) : '0) : dout_q;

  always @(posedge clk) begin
    if (req_valid && req_ready) begin
      accepts <= accepts + 1;
      acc_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && c_read_Nwrite == 2'b01) chk("ack_in_during_write", c_ack_in_read, 0);
    if (prev_rsp) chk("rsp_one_cycle", rsp_valid, 0);
    prev_rsp <= rsp_valid;
    if (rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.rd) chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", rsp_err, mon_e.err);
        if (mon_e.lat != 0) chk("latency", cyc - acc_cyc, mon_e.lat);
        chk("rsp_cache_spacer", {c_addr, c_data_in, c_read_Nwrite, c_ack_in_read}, 0);
      end
    end
  end

  task automatic do_req(input logic w, input logic [1:0] a, input logic [7:0] d,
                        input logic [7:0] md, input int dly, input logic comb, input logic hang);
    exp_t e;
    int n;
    m_data = md; m_delay = dly; m_comb = comb; m_hang = hang;
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", req_ready, 1);
    e.rd    = !w;
    e.err   = hang;
    e.rdata = hang ? last_rd : md;
    e.lat   = hang ? 8'd17 : (comb ? 8'd8 : 8'd0);
    if (!w && !hang) last_rd = md;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (c_read_Nwrite == 2'b00 && n < 10) begin @(negedge clk); n++; end
    chk("drive_c_addr", c_addr, dr2(a));
    chk("drive_c_data_in", c_data_in, w ? dr8(d) : 16'h0);
    chk("drive_c_rnw", c_read_Nwrite, w ? 2'b01 : 2'b10);
    n = 0;
    while (c_read_Nwrite != 2'b00 && n < 60) begin @(negedge clk); n++; end
    chk("spacer_addr_data", {c_addr, c_data_in}, 0);
    chk("ack_in_after_ack", c_ack_in_read, (!w && !hang));
    n = 0;
    while (sb.size() != 0 && n < 60) begin @(negedge clk); n++; end
    chk("rsp_seen", sb.size(), 0);
  endtask

  initial begin
    logic [7:0] rv;
    int a0, n, viol, r0;
    exp_t e;

    repeat (3) @(negedge clk);
    chk("reset_ready", req_ready, 0);
    chk("reset_outputs", {c_addr, c_data_in, c_read_Nwrite, c_ack_in_read, rsp_valid, rsp_err, rsp_rdata}, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", req_ready, 1);

    // Write addr=2 0xA5, cache acks after 3 cycles
    m_data = 8'h00; m_delay = 3; m_comb = 1'b0; m_hang = 1'b0;
    @(negedge clk);
    req_write = 1'b1; req_addr = 2'd2; req_wdata = 8'hA5; req_valid = 1'b1;
    e = '{rd: 1'b0, rdata: 8'h00, err: 1'b0, lat: 8'd0};
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (c_read_Nwrite == 2'b00 && n < 10) begin @(negedge clk); n++; end
    chk("wr_c_addr", c_addr, 4'b1001);
    chk("wr_c_data_in", c_data_in, 16'h9966);
    chk("wr_c_rnw", c_read_Nwrite, 2'b01);
    n = 0;
    while (sb.size() != 0 && n < 60) begin @(negedge clk); n++; end
    chk("wr_rsp_seen", sb.size(), 0);

    // Read addr=1 returning 0x3C, then zero-delay write/read for minimum latency
    do_req(1'b0, 2'd1, 8'h00, 8'h3C, 2, 1'b0, 1'b0);
    do_req(1'b1, 2'd3, 8'h0F, 8'h00, 0, 1'b1, 1'b0);
    do_req(1'b0, 2'd0, 8'h00, 8'hC3, 0, 1'b1, 1'b0);

    // req_valid held through a read
    m_data = 8'h5A; m_delay = 2; m_comb = 1'b0;
    e = '{rd: 1'b1, rdata: 8'h5A, err: 1'b0, lat: 8'd0};
    last_rd = 8'h5A;
    sb.push_back(e);
    @(negedge clk);
    a0 = accepts; viol = 0;
    req_write = 1'b0; req_addr = 2'd0; req_valid = 1'b1;
    n = 0;
    while (n < 80) begin
      @(negedge clk); n++;
      if (accepts != a0) begin
        if (req_ready) viol++;
        if (rsp_valid) break;
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("held_accepts", accepts - a0, 1);
    chk("held_ready_low", viol, 0);
    chk("held_rsp_seen", sb.size(), 0);

    // Reset while waiting for ack
    m_delay = 20; m_comb = 1'b0;
    @(negedge clk);
    req_write = 1'b1; req_addr = 2'd1; req_wdata = 8'h77; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (c_read_Nwrite == 2'b00 && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    r0 = rsp_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_cache_outputs", {c_addr, c_data_in, c_read_Nwrite, c_ack_in_read}, 0);
    chk("rst_no_rsp", rsp_valid, 0);
    chk("rst_ready", req_ready, 1);
    repeat (12) @(negedge clk);
    chk("rst_rsp_count", rsp_cnt - r0, 0);

    // Read ack stuck high before a request
    stuck_r = 1'b1;
    repeat (4) @(negedge clk);
    chk("stuck_ready_low", req_ready, 0);
    a0 = accepts;
    req_write = 1'b0; req_addr = 2'd3; req_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("stuck_no_accept", accepts - a0, 0);
    req_valid = 1'b0;
    stuck_r = 1'b0;
    do_req(1'b0, 2'd3, 8'h00, 8'h96, 1, 1'b0, 1'b0);

    // Random mix
    for (int k = 0; k < 6; k++) begin
      rv = 8'($urandom);
      do_req(1'($urandom), 2'($urandom), rv, ~rv, $urandom_range(0, 4), 1'($urandom), 1'b0);
    end

`ifdef ACK_TIMEOUT_EN
    do_req(1'b0, 2'd2, 8'h00, 8'hEE, 0, 1'b0, 1'b1);
    m_hang = 1'b0;
    do_req(1'b1, 2'd1, 8'h42, 8'h00, 1, 1'b0, 1'b0);
`endif

    repeat (5) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
